// File: rtl/sprite_palette_bank.sv
// Sprite colour palette with NUM_PAL runtime-writable banks.
// Pixel colour indices are mapped to {r,g,b} through a 2-stage read pipeline.
// The displayed bank switches only on frame_start, and a frame-counted hit-flash
// is overlaid on every non-transparent pixel.
// Handshake: rd_valid/rd_idx are accepted every cycle while in RUN. Each accepted
// request yields exactly one out_valid pulse two cycles later, in issue order.
// There is no backpressure.
module sprite_palette_bank #(
    parameter int                       IDX_W        = 4,
    parameter int                       COLOR_W      = 4,
    parameter int                       NUM_PAL      = 4,
    parameter int                       TRANSP_IDX   = 0,
    parameter int                       FLASH_FRAMES = 8,
    parameter logic [3*COLOR_W-1:0]     FLASH_RGB    = 12'hFFF,
    parameter int                       PAL_W        = $clog2(NUM_PAL)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_start,
    input  logic                 wr_en,
    input  logic [PAL_W-1:0]     wr_pal,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [3*COLOR_W-1:0] wr_rgb,
    input  logic [PAL_W-1:0]     sel_pal,
    input  logic                 flash_req,
    input  logic                 rd_valid,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue,
    output logic                 transparent,
    output logic                 out_valid,
    output logic                 busy,
    output logic [PAL_W-1:0]     active_pal,
    output logic                 dbg_state
);

    localparam int DEPTH    = 2 ** IDX_W;
    localparam int ENTRIES  = NUM_PAL * DEPTH;
    localparam int ADDR_W   = PAL_W + IDX_W;
    localparam int RGB_W    = 3 * COLOR_W;
    localparam int FLASH_CW = $clog2(FLASH_FRAMES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [RGB_W-1:0]    mem_q [ENTRIES];
    logic [PAL_W-1:0]    active_pal_q;
    logic [FLASH_CW-1:0] flash_cnt_q;
    logic                flash_on;
    logic                run;
    logic                sel_ok, wr_ok;

    logic                s1_valid_q;
    logic [IDX_W-1:0]    s1_idx_q;
    logic [PAL_W-1:0]    s1_pal_q;
    logic                s1_flash_q;

    logic [RGB_W-1:0]    rd_data;
    logic                s1_transp;
    logic [RGB_W-1:0]    rgb_q;
    logic                transp_q;
    logic                out_valid_q;

    // Bank numbers that do not exist are only possible when NUM_PAL is not a power of two.
    if ((2 ** PAL_W) == NUM_PAL) begin : g_pow2
        assign sel_ok = 1'b1;
        assign wr_ok  = 1'b1;
    end else begin : g_npow2
        assign sel_ok = (int'(sel_pal) < NUM_PAL);
        assign wr_ok  = (int'(wr_pal) < NUM_PAL);
    end

    assign run       = (state_q == ST_RUN);
    assign busy      = (state_q == ST_INIT);
    assign dbg_state = (state_q == ST_RUN);
    assign flash_on  = (flash_cnt_q != '0) && flash_cnt_q[0];

    // Next state: the clear walks every entry bank-major, then the block runs until reset.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // State register and clear counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Palette storage: zero-fill while initialising, host writes once running.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (!run)
                mem_q[clr_cnt_q] <= '0;
            else if (wr_en && wr_ok)
                mem_q[{wr_pal, wr_idx}] <= wr_rgb;
        end
    end

    // Displayed bank latches only at frame boundaries, also during the clear.
    always_ff @(posedge Clk) begin
        if (Reset)
            active_pal_q <= '0;
        else if (frame_start && sel_ok)
            active_pal_q <= sel_pal;
    end

    // Flash countdown: a request reloads and beats a coincident frame tick.
    always_ff @(posedge Clk) begin
        if (Reset)
            flash_cnt_q <= '0;
        else if (flash_req && run)
            flash_cnt_q <= FLASH_CW'(FLASH_FRAMES);
        else if (frame_start && (flash_cnt_q != '0))
            flash_cnt_q <= flash_cnt_q - FLASH_CW'(1);
    end

    // Stage 1: capture the request along with the bank and flash phase it was issued under.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_pal_q   <= '0;
            s1_flash_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_valid && run;
            s1_idx_q   <= rd_idx;
            s1_pal_q   <= active_pal_q;
            s1_flash_q <= flash_on;
        end
    end

    // The array read happens on the same edge as any write, so a same-cycle write is not seen.
    assign rd_data   = mem_q[{s1_pal_q, s1_idx_q}];
    assign s1_transp = (s1_idx_q == IDX_W'(TRANSP_IDX));

    // Stage 2: register colour and flags, with outputs forced to zero when nothing is valid.
    always_ff @(posedge Clk) begin
        if (Reset || !s1_valid_q) begin
            rgb_q       <= '0;
            transp_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            rgb_q       <= (s1_flash_q && !s1_transp) ? FLASH_RGB : rd_data;
            transp_q    <= s1_transp;
            out_valid_q <= 1'b1;
        end
    end

    assign red         = rgb_q[RGB_W-1 -: COLOR_W];
    assign green       = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blue        = rgb_q[COLOR_W-1:0];
    assign transparent = transp_q;
    assign out_valid   = out_valid_q;
    assign active_pal  = active_pal_q;

endmodule
